button_conditioner: RTL and testbench

Synchronises, debounces and one-pulses the raw board push-buttons before they reach the music player's `play_button` / `next_button` inputs. It sits directly upstream of the player's MCU and produces a clean debounced level plus a single-cycle press pulse per button. Each button is handled by an independent channel, so simultaneous presses never interact.

---
 rtl/button_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 141 ++++++++++++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
//------------------------------------------------------------------------------
// Module      : button_pkg
// Description : Channel state encoding and counter-width helpers shared by
//               the button conditioner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package button_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } chan_state_t;

  // Bits needed to count 0 .. n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
//------------------------------------------------------------------------------
// Module      : debounce_channel
// Description : One button: 2-flop synchroniser, debounce FSM, press pulse and
//               optional auto-repeat (macro BUTTON_REPEAT_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);
  import button_pkg::*;

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta, sync;
  chan_state_t   state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          level_nx, pulse_nx;

`ifdef BUTTON_REPEAT_EN
  localparam int            RW        = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_count, rep_count_nx;
  logic          rep_armed, rep_armed_nx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOW;
      count     <= '0;
      level     <= 1'b0;
      pulse     <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      rep_count <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      level     <= level_nx;
      pulse     <= pulse_nx;
`ifdef BUTTON_REPEAT_EN
      rep_count <= rep_count_nx;
      rep_armed <= rep_armed_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    level_nx = level;
    pulse_nx = 1'b0;
    case (state)
      LOW: begin
        if (sync) begin
          state_nx = PEND_HIGH;
          count_nx = '0;
        end
      end
      PEND_HIGH: begin
        if (!sync) begin
          state_nx = LOW;
          count_nx = '0;
        end else if (count == LAST) begin
          state_nx = HIGH;
          count_nx = '0;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      HIGH: begin
        if (!sync) begin
          state_nx = PEND_LOW;
          count_nx = '0;
        end
      end
      PEND_LOW: begin
        if (sync) begin
          state_nx = HIGH;
          count_nx = '0;
        end else if (count == LAST) begin
          state_nx = LOW;
          count_nx = '0;
          level_nx = 1'b0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      default: begin
        state_nx = LOW;
        count_nx = '0;
      end
    endcase

`ifdef BUTTON_REPEAT_EN
    // Repeat timing restarts every time the channel (re)enters HIGH.
    rep_count_nx = '0;
    rep_armed_nx = 1'b0;
    if (state == HIGH && state_nx == HIGH) begin
      rep_armed_nx = rep_armed;
      if (rep_count == (rep_armed ? REP_NEXT : REP_FIRST)) begin
        pulse_nx     = 1'b1;
        rep_armed_nx = 1'b1;
      end else begin
        rep_count_nx = rep_count + RW'(1);
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// Module      : button_conditioner
// Description : NUM_BUTTONS independent debounce/one-pulse channels; auto-repeat
//               enabled by macro BUTTON_REPEAT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] buttons_pulse
);
  import button_pkg::*;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw   (buttons_raw[i]),
      .level (buttons_level[i]),
      .pulse (buttons_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
//------------------------------------------------------------------------------
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] buttons_raw = '0;
  logic [NB-1:0] buttons_level;
  logic [NB-1:0] buttons_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DB)
`ifdef BUTTON_REPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .buttons_level (buttons_level),
    .buttons_pulse (buttons_pulse)
  );

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    logic [1:0] lvl;
    int         pc0;
    int         pc1;
  } seg_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic [1:0] raw, input int cycles);
    buttons_raw = raw;
    reset = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check($sformatf("reset_outs_%0d", i), 32'({buttons_level, buttons_pulse}), 32'h0);
    end
    reset = 1'b1;
  endtask

  initial begin
    seg_t segs[$];
    logic [1:0] exp_p;
    int pc0, pc1;

    // Release bounce on bit0 while bit1 drops cleanly, then bit0 bouncing press,
    // then bit1 rising one cycle after bit0.
    segs.push_back('{2'b00,  2, 2'b11, 0, 0});
    segs.push_back('{2'b01,  3, 2'b11, 0, 0});
    segs.push_back('{2'b00, 10, 2'b01, 0, 0});
    segs.push_back('{2'b00,  1, 2'b00, 0, 0});
    for (int k = 0; k < 10; k++)
      segs.push_back('{(k % 2 == 0) ? 2'b01 : 2'b00, 3, 2'b00, 0, 0});
    segs.push_back('{2'b01, 10, 2'b00, 0, 0});
    segs.push_back('{2'b01,  1, 2'b01, 1, 0});
    segs.push_back('{2'b01,  5, 2'b01, 0, 0});
    segs.push_back('{2'b00, 12, 2'b00, 0, 0});
    segs.push_back('{2'b01,  1, 2'b00, 0, 0});
    segs.push_back('{2'b11,  9, 2'b00, 0, 0});
    segs.push_back('{2'b11,  1, 2'b01, 1, 0});
    segs.push_back('{2'b11,  1, 2'b11, 0, 1});
    segs.push_back('{2'b11,  3, 2'b11, 0, 0});

    // Both buttons held through reset: one pulse each at edge DB+2.
    hold_reset(2'b11, 4);
    for (int e = 0; e < 16; e++) begin
      tick();
      check($sformatf("t1_level_e%0d", e), 32'(buttons_level), (e >= DB + 2) ? 32'h3 : 32'h0);
      check($sformatf("t1_pulse_e%0d", e), 32'(buttons_pulse), (e == DB + 2) ? 32'h3 : 32'h0);
    end

    foreach (segs[s]) begin
      buttons_raw = segs[s].raw;
      pc0 = 0;
      pc1 = 0;
      for (int c = 0; c < segs[s].cycles; c++) begin
        tick();
        pc0 += int'(buttons_pulse[0]);
        pc1 += int'(buttons_pulse[1]);
      end
      check($sformatf("seg%0d_level", s), 32'(buttons_level), 32'(segs[s].lvl));
      check($sformatf("seg%0d_pulses0", s), 32'(pc0), 32'(segs[s].pc0));
      check($sformatf("seg%0d_pulses1", s), 32'(pc1), 32'(segs[s].pc1));
    end

    // Reset in the middle of a pending press.
    hold_reset(2'b00, 2);
    tick();
    tick();
    buttons_raw = 2'b01;
    pc0 = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      pc0 += int'(buttons_pulse[0]);
    end
    check("t5_pending_count", 32'(dut.g_chan[0].u_chan.count), 32'd5);
    reset = 1'b0;
    #1;
    check("t5_count_in_reset", 32'(dut.g_chan[0].u_chan.count), 32'd0);
    for (int e = 0; e < 3; e++) begin
      tick();
      pc0 += int'(buttons_pulse[0]);
    end
    check("t5_no_pulse_aborted", 32'(pc0), 32'd0);
    check("t5_level_in_reset", 32'(buttons_level), 32'h0);
    reset = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      check($sformatf("t5_pulse_e%0d", e), 32'(buttons_pulse), (e == DB + 2) ? 32'h1 : 32'h0);
    end

    // Long hold: auto-repeat when enabled, single pulse otherwise.
    hold_reset(2'b00, 2);
    buttons_raw = 2'b01;
    for (int e = 0; e < DB + 2; e++) tick();
    tick();
    check("t6_accept_pulse", 32'(buttons_pulse), 32'h1);
    for (int k = 1; k <= 60; k++) begin
      tick();
`ifdef BUTTON_REPEAT_EN
      exp_p = (k >= RD && (k - RD) % RP == 0) ? 2'b01 : 2'b00;
`else
      exp_p = 2'b00;
`endif
      check($sformatf("t6_pulse_k%0d", k), 32'(buttons_pulse), 32'(exp_p));
    end
    check("t6_level_held", 32'(buttons_level), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
